// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Define ALU_ARB_RR_EN for round-robin; default is fixed priority (req 0 wins).
module alu_arbiter #(
  parameter int DW  = 32,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req,
  input  logic [OPW-1:0] opcode0,
  input  logic [OPW-1:0] opcode1,
  input  logic [DW-1:0]  a0,
  input  logic [DW-1:0]  a1,
  input  logic [DW-1:0]  b0,
  input  logic [DW-1:0]  b1,
  output logic [1:0]     gnt,
  output logic [1:0]     rvalid,
  output logic [DW-1:0]  rdata,
  output logic           busy,
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  aluout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic           owner_q;
  logic [1:0]     rvalid_q;
  logic           busy_q;
  logic [DW-1:0]  rdata_q;
  logic [OPW-1:0] alu_op_q;
  logic [DW-1:0]  alu_a_q;
  logic [DW-1:0]  alu_b_q;
  logic           sel_d;
  logic           take_d;
`ifdef ALU_ARB_RR_EN
  logic           last_q;
`endif

  // Pick the winner among active requests (1 = requester 1)
  always_comb begin
    sel_d = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (req == 2'b11) begin
      sel_d = ~last_q;
    end else begin
      sel_d = req[1];
    end
`else
    sel_d = req[1] & ~req[0];
`endif
  end

  // A grant can only be issued from IDLE or DONE, never under reset
  assign take_d = reset & (state_q != EXEC) & (|req);
  assign gnt    = take_d ? {sel_d, ~sel_d} : 2'b00;

  // Control FSM with registered ALU drive and result return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rvalid_q <= 2'b00;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
`ifdef ALU_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      rvalid_q <= 2'b00;
      case (state_q)
        EXEC: begin
          rdata_q  <= aluout;
          rvalid_q <= {owner_q, ~owner_q};
          state_q  <= DONE;
        end
        default: begin
          if (take_d) begin
            alu_op_q <= sel_d ? opcode1 : opcode0;
            alu_a_q  <= sel_d ? a1 : a0;
            alu_b_q  <= sel_d ? b1 : b0;
            owner_q  <= sel_d;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
`ifdef ALU_ARB_RR_EN
            last_q   <= sel_d;
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction model.
// Build with ALU_ARB_RR_EN to exercise the round-robin variant.
module tb_alu_arbiter;
  localparam int DW  = 32;
  localparam int OPW = 5;

  localparam logic [OPW-1:0] ADD = 5'd0;
  localparam logic [OPW-1:0] SUB = 5'd1;
  localparam logic [OPW-1:0] XOR = 5'd4;
  localparam logic [OPW-1:0] LSF = 5'd5;
  localparam logic [OPW-1:0] JEQ = 5'd7;
  localparam logic [OPW-1:0] JLT = 5'd8;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req;
  logic [OPW-1:0] opcode0, opcode1;
  logic [DW-1:0]  a0, a1, b0, b1;
  logic [1:0]     gnt, rvalid;
  logic [DW-1:0]  rdata;
  logic           busy;
  logic [OPW-1:0] alu_opcode;
  logic [DW-1:0]  alu_a, alu_b, aluout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ALU stand-in: plain arithmetic, unknown opcodes yield 0
  function automatic logic [DW-1:0] alu_f(
    logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      XOR:     return a ^ b;
      LSF:     return a << b[4:0];
      JEQ:     return DW'(a == b);
      JLT:     return DW'($signed(a) < $signed(b));
      default: return '0;
    endcase
  endfunction

  assign aluout = alu_f(alu_opcode, alu_a, alu_b);

  alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .opcode0(opcode0), .opcode1(opcode1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .aluout(aluout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Transaction model: at most one op outstanding, result 2 cycles after grant
  bit             m_pend, m_own, m_last, m_can, w;
  int             m_due;
  logic [OPW-1:0] m_op;
  logic [DW-1:0]  m_a, m_b, m_res;
  logic [1:0]     exp_gnt, exp_rv, gnt_seen;
  logic [1:0]     dq[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_alu_op", alu_opcode, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      m_pend = 0;
      m_last = 1;
      m_op = '0;
      m_a = '0;
      m_b = '0;
    end else begin
      m_can = !m_pend || (m_due == cyc);
      exp_rv = 2'b00;
      if (m_pend && m_due == cyc) exp_rv = m_own ? 2'b10 : 2'b01;
      chk("rvalid", rvalid, exp_rv);
      if (exp_rv != 2'b00) chk("rdata", rdata, m_res);
      chk("busy", busy, m_pend);
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (m_pend && m_due == cyc) m_pend = 0;
      exp_gnt = 2'b00;
      if (m_can && req != 2'b00) begin
`ifdef ALU_ARB_RR_EN
        w = (req == 2'b11) ? ~m_last : req[1];
`else
        w = (req == 2'b10);
`endif
        exp_gnt = w ? 2'b10 : 2'b01;
      end
      chk("gnt", gnt, exp_gnt);
      if (gnt != 2'b00) dq.push_back(gnt);
      if (exp_gnt != 2'b00) begin
        m_pend = 1;
        m_due = cyc + 2;
        m_own = w;
        m_last = w;
        m_op = w ? opcode1 : opcode0;
        m_a = w ? a1 : a0;
        m_b = w ? b1 : b0;
        m_res = alu_f(m_op, m_a, m_b);
      end
    end
    gnt_seen = gnt;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int r, logic [OPW-1:0] op,
                        logic [DW-1:0] a, logic [DW-1:0] b);
    if (r == 0) begin
      opcode0 = op; a0 = a; b0 = b;
    end else begin
      opcode1 = op; a1 = a; b1 = b;
    end
  endtask

  // One isolated op from an idle arbiter with a literal result
  task automatic op_lit(string nm, int r, logic [OPW-1:0] op,
                        logic [DW-1:0] a, logic [DW-1:0] b,
                        logic [DW-1:0] exp);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    set_op(r, op, a, b);
    req = oh;
    @(negedge clk);
    chk({nm, "_gnt"}, gnt, oh);
    tick();
    req = 2'b00;
    tick();
    @(negedge clk);
    chk({nm, "_rvalid"}, rvalid, oh);
    chk({nm, "_rdata"}, rdata, exp);
    tick();
    @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
    tick();
  endtask

  initial begin
    logic [1:0] e;
    reset = 1'b0;
    req = 2'b00;
    set_op(0, '0, '0, '0);
    set_op(1, '0, '0, '0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    // T1 single op
    set_op(0, ADD, 5, 7);
    req = 2'b01;
    @(negedge clk);
    chk("T1_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    @(negedge clk);
    chk("T1_alu_a", alu_a, 5);
    chk("T1_alu_b", alu_b, 7);
    chk("T1_busy1", busy, 1);
    tick();
    @(negedge clk);
    chk("T1_rvalid", rvalid, 2'b01);
    chk("T1_rdata", rdata, 12);
    chk("T1_busy2", busy, 1);
    tick();
    @(negedge clk);
    chk("T1_busy3", busy, 0);
    tick();

    // T2 back-to-back from requester 0
    set_op(0, SUB, 10, 3);
    req = 2'b01;
    @(negedge clk);
    chk("T2_gnt1", gnt, 2'b01);
    tick();
    set_op(0, XOR, 32'hF0, 32'h0F);
    tick();
    @(negedge clk);
    chk("T2_rv1", rvalid, 2'b01);
    chk("T2_rd1", rdata, 7);
    chk("T2_gnt2", gnt, 2'b01);
    tick();
    req = 2'b00;
    tick();
    @(negedge clk);
    chk("T2_rv2", rvalid, 2'b01);
    chk("T2_rd2", rdata, 32'hFF);
    repeat (2) tick();

    // T3 contention from a fresh pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    dq.delete();
    set_op(0, ADD, 1, 1);
    set_op(1, ADD, 2, 2);
    req = 2'b11;
    repeat (7) tick();
    req = 2'b00;
    repeat (3) tick();
    chk("T3_count", dq.size(), 4);
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      e = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      e = 2'b01;
`endif
      chk("T3_order", dq[i], e);
    end

    // T4 reset during EXEC
    set_op(0, LSF, 1, 4);
    req = 2'b01;
    @(negedge clk);
    chk("T4_gnt", gnt, 2'b01);
    tick();
    req = 2'b00;
    reset = 1'b0;
    #1;
    chk("T4_busy", busy, 0);
    chk("T4_alu_a", alu_a, 0);
    chk("T4_alu_b", alu_b, 0);
    chk("T4_rvalid", rvalid, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("T4_no_rvalid", rvalid, 0);
      tick();
    end
    op_lit("T4_after", 0, ADD, 2, 3, 5);

    // T5 request withdrawn in grant cycle, T6 compares, undefined op
    op_lit("T5", 1, SUB, 100, 1, 99);
    op_lit("T6_jlt", 1, JLT, 3, 9, 1);
    op_lit("T6_jeq", 1, JEQ, 4, 5, 0);
    op_lit("undef", 0, 5'd20, 7, 7, 0);

    // Random traffic with withdrawals and occasional resets
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (req[r] && gnt_seen[r]) begin
          req[r] = 1'b0;
        end else if (req[r] && $urandom_range(0, 15) == 0) begin
          req[r] = 1'b0;
        end else if (!req[r] && $urandom_range(0, 2) == 0) begin
          logic [DW-1:0] ra, rb;
          ra = $urandom;
          rb = ($urandom_range(0, 3) == 0) ? ra : DW'($urandom_range(0, 40));
          set_op(r, OPW'($urandom_range(0, 15)), ra, rb);
          req[r] = 1'b1;
        end
      end
    end
    reset = 1'b1;
    req = 2'b00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
